// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// present (captured at dispatch or from the CDB broadcast buses), then hands
// the oldest ready op to the ALU through a registered issue port.
//
// Issue handshake: the issue register presents an op while iss_valid is high;
// the op is consumed on a clock edge where iss_valid & iss_ready & rdy are all
// high. While iss_valid is high and iss_ready is low, every iss_* field holds.
module alu_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  output logic                        full,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  input  logic                        disp_valid,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [DATA_W-1:0]           disp_imm,
  input  logic [ADDR_W-1:0]           disp_pc,
  input  logic                        disp_src1_rdy,
  input  logic [DATA_W-1:0]           disp_src1_data,
  input  logic [TAG_W-1:0]            disp_src1_tag,
  input  logic                        disp_src2_rdy,
  input  logic [DATA_W-1:0]           disp_src2_data,
  input  logic [TAG_W-1:0]            disp_src2_tag,
  input  logic [TAG_W-1:0]            disp_dest_tag,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [OP_W-1:0]             iss_op,
  output logic [DATA_W-1:0]           iss_src1,
  output logic [DATA_W-1:0]           iss_src2,
  output logic [DATA_W-1:0]           iss_imm,
  output logic [ADDR_W-1:0]           iss_pc,
  output logic [TAG_W-1:0]            iss_dest_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1_data;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2_data;
    logic [TAG_W-1:0]  s2_tag;
    logic [TAG_W-1:0]  dest;
    logic [IDX_W-1:0]  age;     // 0 = oldest valid entry
  } entry_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic [TAG_W-1:0]  dest;
  } iss_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  iss_t             iss_q, iss_d;

  logic             full_w;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_age;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             issue_load;
  logic             take;
  logic             disp_acc;

  // Returns {hit, data}; the lowest-index matching valid channel wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  t,
    input logic [NUM_CDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (v[c] && (t[c*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, d[c*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  assign full_w = (count_q == CNT_W'(DEPTH));

  // Select the ready entry with the smallest age (registered state only).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy &&
          (!sel_found || (ent_q[i].age < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_q[i].age;
      end
    end
  end

  // Find the lowest-index free slot for dispatch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next state: wakeup, issue-register load with age compaction, dispatch.
  always_comb begin
    logic [DATA_W:0] look;
    look       = '0;
    ent_d      = ent_q;
    count_d    = count_q;
    iss_d      = iss_q;
    issue_load = !iss_q.valid || iss_ready;
    take       = issue_load && sel_found;
    disp_acc   = disp_valid && !full_w && free_found;

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (!ent_q[i].s1_rdy) begin
          look = cdb_lookup(ent_q[i].s1_tag, cdb_valid, cdb_tag, cdb_data);
          if (look[DATA_W]) begin
            ent_d[i].s1_rdy  = 1'b1;
            ent_d[i].s1_data = look[DATA_W-1:0];
          end
        end
        if (!ent_q[i].s2_rdy) begin
          look = cdb_lookup(ent_q[i].s2_tag, cdb_valid, cdb_tag, cdb_data);
          if (look[DATA_W]) begin
            ent_d[i].s2_rdy  = 1'b1;
            ent_d[i].s2_data = look[DATA_W-1:0];
          end
        end
      end
    end

    if (issue_load) begin
      iss_d.valid = sel_found;
      if (sel_found) begin
        iss_d.op   = ent_q[sel_idx].op;
        iss_d.src1 = ent_q[sel_idx].s1_data;
        iss_d.src2 = ent_q[sel_idx].s2_data;
        iss_d.imm  = ent_q[sel_idx].imm;
        iss_d.pc   = ent_q[sel_idx].pc;
        iss_d.dest = ent_q[sel_idx].dest;
      end
    end

    if (take) begin
      ent_d[sel_idx].valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && (ent_q[i].age > sel_age)) begin
          ent_d[i].age = ent_q[i].age - 1'b1;
        end
      end
    end

    if (disp_acc) begin
      ent_d[free_idx].valid   = 1'b1;
      ent_d[free_idx].op      = disp_op;
      ent_d[free_idx].imm     = disp_imm;
      ent_d[free_idx].pc      = disp_pc;
      ent_d[free_idx].s1_rdy  = disp_src1_rdy;
      ent_d[free_idx].s1_data = disp_src1_data;
      ent_d[free_idx].s1_tag  = disp_src1_tag;
      ent_d[free_idx].s2_rdy  = disp_src2_rdy;
      ent_d[free_idx].s2_data = disp_src2_data;
      ent_d[free_idx].s2_tag  = disp_src2_tag;
      ent_d[free_idx].dest    = disp_dest_tag;
      ent_d[free_idx].age     = IDX_W'(count_q - CNT_W'(take));
      if (!disp_src1_rdy) begin
        look = cdb_lookup(disp_src1_tag, cdb_valid, cdb_tag, cdb_data);
        if (look[DATA_W]) begin
          ent_d[free_idx].s1_rdy  = 1'b1;
          ent_d[free_idx].s1_data = look[DATA_W-1:0];
        end
      end
      if (!disp_src2_rdy) begin
        look = cdb_lookup(disp_src2_tag, cdb_valid, cdb_tag, cdb_data);
        if (look[DATA_W]) begin
          ent_d[free_idx].s2_rdy  = 1'b1;
          ent_d[free_idx].s2_data = look[DATA_W-1:0];
        end
      end
    end

    count_d = count_q + CNT_W'(disp_acc) - CNT_W'(take);
  end

  // State register: reset always clears; flush clears when enabled; rdy=0 freezes.
  always_ff @(posedge clk) begin
    if (rst || (rdy && flush)) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      iss_q   <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
      iss_q   <= iss_d;
    end
  end

  assign full         = full_w;
  assign count        = count_q;
  assign iss_valid    = iss_q.valid;
  assign iss_op       = iss_q.op;
  assign iss_src1     = iss_q.src1;
  assign iss_src2     = iss_q.src2;
  assign iss_imm      = iss_q.imm;
  assign iss_pc       = iss_q.pc;
  assign iss_dest_tag = iss_q.dest;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: expected issued ops are queued as
// stimulus is applied and checked in order by an independent issue monitor.
module tb_alu_issue_queue;

  localparam int DEPTH   = 8;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;
  localparam int NUM_CDB = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int EW      = OP_W + 3 * DATA_W + ADDR_W + TAG_W;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       rdy = 1'b1;
  logic                       flush = 1'b0;
  logic                       full;
  logic [CNT_W-1:0]           count;
  logic                       disp_valid = 1'b0;
  logic [OP_W-1:0]            disp_op = '0;
  logic [DATA_W-1:0]          disp_imm = '0;
  logic [ADDR_W-1:0]          disp_pc = '0;
  logic                       disp_src1_rdy = 1'b0;
  logic [DATA_W-1:0]          disp_src1_data = '0;
  logic [TAG_W-1:0]           disp_src1_tag = '0;
  logic                       disp_src2_rdy = 1'b0;
  logic [DATA_W-1:0]          disp_src2_data = '0;
  logic [TAG_W-1:0]           disp_src2_tag = '0;
  logic [TAG_W-1:0]           disp_dest_tag = '0;
  logic [NUM_CDB-1:0]         cdb_valid = '0;
  logic [NUM_CDB*TAG_W-1:0]   cdb_tag = '0;
  logic [NUM_CDB*DATA_W-1:0]  cdb_data = '0;
  logic                       iss_valid;
  logic                       iss_ready = 1'b1;
  logic [OP_W-1:0]            iss_op;
  logic [DATA_W-1:0]          iss_src1;
  logic [DATA_W-1:0]          iss_src2;
  logic [DATA_W-1:0]          iss_imm;
  logic [ADDR_W-1:0]          iss_pc;
  logic [TAG_W-1:0]           iss_dest_tag;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_issue_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .full(full), .count(count),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_data(disp_src1_data), .disp_src1_tag(disp_src1_tag),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_data(disp_src2_data), .disp_src2_tag(disp_src2_tag),
    .disp_dest_tag(disp_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_imm(iss_imm),
    .iss_pc(iss_pc), .iss_dest_tag(iss_dest_tag)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk_exp(input logic [OP_W-1:0] op,
                                           input logic [DATA_W-1:0] s1,
                                           input logic [DATA_W-1:0] s2,
                                           input logic [TAG_W-1:0] dest);
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    imm = 32'h100 + 32'(op);
    pc  = 32'h4000 + 32'(op);
    return {op, s1, s2, imm, pc, dest};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [OP_W-1:0] op,
                          input logic s1r, input logic [DATA_W-1:0] s1d, input logic [TAG_W-1:0] s1t,
                          input logic s2r, input logic [DATA_W-1:0] s2d, input logic [TAG_W-1:0] s2t,
                          input logic [TAG_W-1:0] dest);
    disp_valid     = 1'b1;
    disp_op        = op;
    disp_imm       = 32'h100 + 32'(op);
    disp_pc        = 32'h4000 + 32'(op);
    disp_src1_rdy  = s1r;
    disp_src1_data = s1d;
    disp_src1_tag  = s1t;
    disp_src2_rdy  = s2r;
    disp_src2_data = s2d;
    disp_src2_tag  = s2t;
    disp_dest_tag  = dest;
    step();
    disp_valid     = 1'b0;
  endtask

  task automatic cdb_set(input int ch, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid[ch]                = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W]   = tag;
    cdb_data[ch*DATA_W +: DATA_W] = data;
  endtask

  task automatic cdb_clear();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iss_valid) && n < 200) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Issue monitor: compare every consumed op against the expected queue.
  always @(negedge clk) begin
    if (!rst && !flush && rdy && iss_valid && iss_ready) begin
      logic [EW-1:0] got, exp;
      got = {iss_op, iss_src1, iss_src2, iss_imm, iss_pc, iss_dest_tag};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %0h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL issue_order: got %0h expected %0h", got, exp);
        end
      end
    end
  end

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_iss_op", 64'(iss_op), 64'd0);
    check("rst_iss_src1", 64'(iss_src1), 64'd0);
    check("rst_iss_dest", 64'(iss_dest_tag), 64'd0);

    // 1: single ready op, two-edge latency
    iss_ready = 1'b1;
    exp_q.push_back(mk_exp(6'h01, 32'd5, 32'd7, 4'd3));
    dispatch(6'h01, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    check("t1_not_yet_valid", 64'(iss_valid), 64'd0);
    check("t1_count_after_disp", 64'(count), 64'd1);
    step();
    check("t1_valid_after_2", 64'(iss_valid), 64'd1);
    check("t1_count_after_issue", 64'(count), 64'd0);
    drain("t1_drain");

    // 2: pending A overtaken by ready B, A woken by CDB ch1
    exp_q.push_back(mk_exp(6'h03, 32'h1, 32'h2, 4'd5));
    exp_q.push_back(mk_exp(6'h02, 32'h99, 32'h10, 4'd4));
    dispatch(6'h02, 1'b0, 32'h0, 4'd2, 1'b1, 32'h10, 4'd0, 4'd4);
    dispatch(6'h03, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 4'd5);
    step();
    step();
    cdb_set(1, 4'd2, 32'h99);
    step();
    cdb_clear();
    drain("t2_drain");

    // 3: age order beats slot order; back-pressure holds the issue register
    iss_ready = 1'b0;
    exp_q.push_back(mk_exp(6'h09, 32'h91, 32'h92, 4'd1));
    exp_q.push_back(mk_exp(6'h04, 32'hA1, 32'hA2, 4'd6));
    exp_q.push_back(mk_exp(6'h05, 32'hB1, 32'hB2, 4'd7));
    dispatch(6'h09, 1'b1, 32'h91, 4'd0, 1'b1, 32'h92, 4'd0, 4'd1);
    dispatch(6'h04, 1'b1, 32'hA1, 4'd0, 1'b1, 32'hA2, 4'd0, 4'd6);
    dispatch(6'h05, 1'b1, 32'hB1, 4'd0, 1'b1, 32'hB2, 4'd0, 4'd7);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_op", 64'(iss_op), 64'h09);
      check("t3_hold_src1", 64'(iss_src1), 64'h91);
      check("t3_hold_count", 64'(count), 64'd2);
      step();
    end
    iss_ready = 1'b1;
    drain("t3_drain");

    // 4: fill to DEPTH; 9th dispatch dropped while the issue register drains
    iss_ready = 1'b0;
    exp_q.push_back(mk_exp(6'h06, 32'h61, 32'h62, 4'd8));
    dispatch(6'h06, 1'b1, 32'h61, 4'd0, 1'b1, 32'h62, 4'd0, 4'd8);
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(6'(8'h10 + i), 1'b0, 32'h0, 4'd9, 1'b1, 32'(32'h20 + i), 4'd0, 4'(i));
    end
    check("t4_full", 64'(full), 64'd1);
    check("t4_count_full", 64'(count), 64'd8);
    iss_ready = 1'b1;
    dispatch(6'h1F, 1'b1, 32'h77, 4'd0, 1'b1, 32'h78, 4'd0, 4'd15);
    check("t4_count_after_drop", 64'(count), 64'd8);
    check("t4_full_after_drop", 64'(full), 64'd1);
    check("t4_iss_empty", 64'(iss_valid), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(mk_exp(6'(8'h10 + i), 32'h55, 32'(32'h20 + i), 4'(i)));
    end
    cdb_set(2, 4'd9, 32'h55);
    step();
    cdb_clear();
    drain("t4_drain");
    check("t4_count_end", 64'(count), 64'd0);

    // 5: dispatch-cycle capture and wakeup both take the lowest channel
    exp_q.push_back(mk_exp(6'h07, 32'h3, 32'h11, 4'd2));
    cdb_set(0, 4'd5, 32'h11);
    cdb_set(3, 4'd5, 32'h22);
    dispatch(6'h07, 1'b1, 32'h3, 4'd0, 1'b0, 32'h0, 4'd5, 4'd2);
    cdb_clear();
    drain("t5_disp_capture");
    exp_q.push_back(mk_exp(6'h08, 32'h33, 32'h4, 4'd9));
    dispatch(6'h08, 1'b0, 32'h0, 4'd6, 1'b1, 32'h4, 4'd0, 4'd9);
    cdb_set(1, 4'd6, 32'h33);
    cdb_set(2, 4'd6, 32'h44);
    step();
    cdb_clear();
    drain("t5_wake_priority");

    // 6: flush beats a simultaneous dispatch
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dispatch(6'(8'h20 + i), 1'b1, 32'(i), 4'd0, 1'b1, 32'(i + 1), 4'd0, 4'(i));
    end
    check("t6_count_before", 64'(count), 64'd4);
    check("t6_valid_before", 64'(iss_valid), 64'd1);
    flush = 1'b1;
    dispatch(6'h2A, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 4'd3);
    flush = 1'b0;
    check("t6_flush_count", 64'(count), 64'd0);
    check("t6_flush_valid", 64'(iss_valid), 64'd0);
    check("t6_flush_op", 64'(iss_op), 64'd0);
    check("t6_flush_full", 64'(full), 64'd0);
    iss_ready = 1'b1;
    step();
    step();
    check("t6_stays_empty", 64'(iss_valid), 64'd0);

    // 6b: reset pulse mid-stream
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dispatch(6'(8'h30 + i), 1'b1, 32'(i), 4'd0, 1'b1, 32'(i), 4'd0, 4'(i));
    end
    check("t6b_count_before", 64'(count), 64'd2);
    rst = 1'b1;
    dispatch(6'h3A, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 4'd3);
    rst = 1'b0;
    check("t6b_rst_count", 64'(count), 64'd0);
    check("t6b_rst_valid", 64'(iss_valid), 64'd0);
    check("t6b_rst_src2", 64'(iss_src2), 64'd0);

    // 7: rdy=0 freezes dispatch and issue
    rdy = 1'b0;
    dispatch(6'h0B, 1'b1, 32'hC1, 4'd0, 1'b1, 32'hC2, 4'd0, 4'd4);
    check("t7_frozen_count", 64'(count), 64'd0);
    rdy = 1'b1;
    exp_q.push_back(mk_exp(6'h0A, 32'hD1, 32'hD2, 4'd5));
    dispatch(6'h0A, 1'b1, 32'hD1, 4'd0, 1'b1, 32'hD2, 4'd0, 4'd5);
    step();
    rdy = 1'b0;
    iss_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_frozen_valid", 64'(iss_valid), 64'd1);
      check("t7_frozen_op", 64'(iss_op), 64'h0A);
    end
    rdy = 1'b1;
    drain("t7_drain");
    check("end_count", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
